// File: rtl/dcm_spi_pkg.sv
// Shared definitions for the dcmctrl SPI initiator.
// Optional abort input is enabled by defining DCM_SPI_MASTER_ABORT_EN.
package dcm_spi_pkg;

    // Bits per SPI byte, shifted MSB first
    localparam int SPI_BITS = 8;

    // Command byte fields understood by the dcmctrl SPI slave
    localparam logic [7:0] CMD_WRITE  = 8'h80;
    localparam logic [7:0] CMD_CH_SEL = 8'h40;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_HOLD  = 3'd5
    } spi_state_e;

    // Largest of three timing parameters, used to size the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/dcm_spi_tick.sv
// Loadable down-counter with a terminal-count flag. The count parks at
// zero rather than wrapping, so done_o stays high until the next load.
module dcm_spi_tick #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload wins, otherwise count down and stop at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dcm_spi_master.sv
// SPI mode-3 initiator for the dcmctrl slave port. A byte stream arriving
// on tx_* is framed as one slave-select transaction; every MISO byte is
// returned on a one-cycle rx_valid strobe.
// Optional: define DCM_SPI_MASTER_ABORT_EN to add the abort input.
//
// Handshake: a byte moves on any clk edge where tx_valid && tx_ready; the
// producer must hold tx_data/tx_last stable while tx_valid is high and not
// yet accepted. tx_ready is only high in IDLE and in NEXT before a byte has
// been taken for the inter-byte gap.
module dcm_spi_master
    import dcm_spi_pkg::*;
#(
    parameter int CLK_DIV  = 5,
    parameter int SS_SETUP = 5,
    parameter int SS_HOLD  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_ss,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
`ifdef DCM_SPI_MASTER_ABORT_EN
    input  logic       abort,
`endif
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(max3(CLK_DIV, SS_SETUP, SS_HOLD) + 1);
    localparam int BW = $clog2(SPI_BITS);

    // Timer reload values: a state entered with value N-1 lasts N cycles
    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(SS_HOLD - 1);

    spi_state_e     state_q;
    logic [7:0]     tx_shift_q;
    logic [7:0]     rx_shift_q;
    logic [BW-1:0]  bit_idx_q;
    logic           last_q;
    logic           gap_q;
    logic           ss_q;
    logic           sclk_q;
    logic           mosi_q;
    logic [7:0]     rx_data_q;
    logic           rx_valid_q;
    logic           busy_q;

    logic           abort_hit;
    logic           accept;
    logic           tick_load;
    logic [CW-1:0]  tick_val;
    logic           tick_done;

`ifdef DCM_SPI_MASTER_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE) && (state_q != ST_HOLD);
`else
    assign abort_hit = 1'b0;
`endif

    // Ready is gated by reset so nothing is offered while reset is asserted
    assign tx_ready = reset && !abort_hit &&
                      ((state_q == ST_IDLE) || ((state_q == ST_NEXT) && !gap_q));
    assign accept   = tx_valid && tx_ready;

    // Timer reload decode: reload on every edge that enters a timed state
    always_comb begin
        tick_load = 1'b0;
        tick_val  = '0;
        if (abort_hit) begin
            tick_load = 1'b1;
            tick_val  = HOLD_LD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tick_load = 1'b1;
                        tick_val  = SETUP_LD;
                    end
                end
                ST_SETUP, ST_LOW: begin
                    if (tick_done) begin
                        tick_load = 1'b1;
                        tick_val  = DIV_LD;
                    end
                end
                ST_HIGH: begin
                    if (tick_done) begin
                        tick_load = 1'b1;
                        // NEXT is untimed until a byte arrives, so only the
                        // final byte of a transaction needs the hold value
                        tick_val  = ((bit_idx_q == '0) && last_q) ? HOLD_LD : DIV_LD;
                    end
                end
                ST_NEXT: begin
                    if (!gap_q) begin
                        if (accept) begin
                            tick_load = 1'b1;
                            tick_val  = DIV_LD;
                        end
                    end else if (tick_done) begin
                        tick_load = 1'b1;
                        tick_val  = DIV_LD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dcm_spi_tick #(
        .W (CW)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tick_load),
        .load_val_i (tick_val),
        .done_o     (tick_done)
    );

    // Transaction sequencer with registered SPI pins and rx strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_idx_q  <= '0;
            last_q     <= 1'b0;
            gap_q      <= 1'b0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (abort_hit) begin
                // Partial byte is dropped; hold timing still applies
                state_q <= ST_HOLD;
                ss_q    <= 1'b1;
                sclk_q  <= 1'b1;
                gap_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            tx_shift_q <= tx_data;
                            last_q     <= tx_last;
                            ss_q       <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (tick_done) begin
                            sclk_q    <= 1'b0;
                            mosi_q    <= tx_shift_q[7];
                            bit_idx_q <= BW'(SPI_BITS - 1);
                            state_q   <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (tick_done) begin
                            sclk_q     <= 1'b1;
                            rx_shift_q <= {rx_shift_q[6:0], spi_miso};
                            state_q    <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (tick_done) begin
                            if (bit_idx_q != '0) begin
                                bit_idx_q  <= bit_idx_q - 1'b1;
                                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                                sclk_q     <= 1'b0;
                                mosi_q     <= tx_shift_q[6];
                                state_q    <= ST_LOW;
                            end else begin
                                rx_data_q  <= rx_shift_q;
                                rx_valid_q <= 1'b1;
                                if (last_q) begin
                                    ss_q    <= 1'b1;
                                    state_q <= ST_HOLD;
                                end else begin
                                    state_q <= ST_NEXT;
                                end
                            end
                        end
                    end
                    ST_NEXT: begin
                        if (!gap_q) begin
                            if (accept) begin
                                tx_shift_q <= tx_data;
                                last_q     <= tx_last;
                                gap_q      <= 1'b1;
                            end
                        end else if (tick_done) begin
                            gap_q     <= 1'b0;
                            sclk_q    <= 1'b0;
                            mosi_q    <= tx_shift_q[7];
                            bit_idx_q <= BW'(SPI_BITS - 1);
                            state_q   <= ST_LOW;
                        end
                    end
                    ST_HOLD: begin
                        if (tick_done) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign spi_ss    = ss_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: doc/dcm_spi_master.md
Name: dcm_spi_master

Overview:
- SPI initiator that drives the dcmctrl SPI slave port from on-chip logic (host bridge, self-test sequencer) in place of an external controller.
- Accepts a byte stream over a valid/ready handshake and frames it as one SPI transaction: command byte, then data bytes.
- Returns every MISO byte on an rx strobe.
- Mode 3 wire protocol: clock idles high; MOSI changes on the falling edge; both sides sample on the rising edge; MSB first; active-low ss.

Parameters:
- CLK_DIV, 5, SPI half-period in clk cycles (>=1); 5 gives 50 ns half-period at 100 MHz.
- SS_SETUP, 5, clk cycles ss is low before the first falling edge (>=1).
- SS_HOLD, 10, clk cycles ss is held high after a transaction before a new one may start (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- tx_data  in  8  byte to send
- tx_last  in  1  qualifies tx_data as the final byte of the transaction
- tx_valid  in  1  tx_data/tx_last valid
- tx_ready  out  1  byte accepted when tx_valid && tx_ready
- rx_data  out  8  byte captured from MISO
- rx_valid  out  1  one-cycle strobe, rx_data valid
- busy  out  1  high from acceptance of the first byte until SS_HOLD expires
- spi_ss  out  1  slave select, active low
- spi_clk  out  1  SPI clock, idle high
- spi_mosi  out  1  master out
- spi_miso  in  1  master in (synchronous to this block's own clock edges; no synchroniser)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - spi_ss=1, spi_clk=1, spi_mosi=0
  - tx_ready=0, rx_valid=0, rx_data=0, busy=0
  - state IDLE
- States: IDLE, SETUP, LOW, HIGH, NEXT, HOLD.
- tx_ready is combinational: 1 only in IDLE and NEXT.
- IDLE: on accept, latch byte and last flag, spi_ss<=0, busy<=1 -> SETUP.
- SETUP: wait SS_SETUP cycles -> LOW with bit index 7.
- LOW:
  - On entry, spi_clk<=0 and spi_mosi<=shift[7].
  - Hold CLK_DIV cycles -> HIGH.
- HIGH:
  - On entry, spi_clk<=1 and spi_miso is shifted into the rx shift register, LSB in.
  - Hold CLK_DIV cycles. If bits remain: shift tx, -> LOW.
  - After the 8th bit: rx_data<=captured byte and rx_valid=1 for exactly one cycle. Then -> HOLD if the latched last flag is set, else -> NEXT.
- NEXT:
  - spi_clk stays 1 and spi_ss stays 0 while waiting indefinitely for tx_valid (stall).
  - On accept, latch the byte and wait CLK_DIV cycles as an inter-byte gap -> LOW.
- HOLD: spi_ss<=1 on entry; wait SS_HOLD cycles; busy<=0 -> IDLE.
- Bit period is 2*CLK_DIV clk cycles. Per byte: 16*CLK_DIV cycles plus a CLK_DIV gap.
- spi_mosi holds the last bit value between bytes and after the transaction; spi_mosi<=0 only on reset.
- tx_valid while not ready: the byte is held off and no side effect occurs.
- A 1-byte transaction (tx_last on the first byte) is legal.
- Counter width is $clog2(max(CLK_DIV, SS_SETUP, SS_HOLD)+1). The counter saturates at zero; no wrap.

Optional Feature:
DCM_SPI_MASTER_ABORT_EN
- With the macro: adds input abort (1 bit). In any state except IDLE and HOLD, abort=1 moves the block to HOLD on the next clk edge:
  - spi_ss=1, spi_clk=1
  - partial byte discarded, no rx_valid
  - a byte offered in the same cycle is not accepted (tx_ready forced 0)
  - abort in IDLE or HOLD is ignored.
- Without the macro: no abort port; a transaction ends only after a tx_last byte or on reset.

Decomposition:
- Package dcm_spi_pkg: state enum, SPI_BITS=8, command constants shared with dcmctrl (CMD_WRITE=8'h80, CMD_CH_SEL=8'h40).
- Sub-module dcm_spi_tick: loadable down-counter with a done flag, used for CLK_DIV, SS_SETUP and SS_HOLD timing.

Test Plan:
- Send 8'hC0, 100, 0, 0, 20 (tx_last on 20), slave model attached -> dcmctrl channel 0 target speed=100, position=20.
  - Also check: 5 bytes seen with MSB first; ss low for 5*16*CLK_DIV + gaps.
- Loopback spi_miso=spi_mosi, send 8'hA5, 8'h3C -> rx_valid pulses twice with rx_data 8'hA5 then 8'h3C, each exactly one cycle wide.
- Drop tx_valid for 200 cycles after the first byte -> spi_ss stays 0, spi_clk stays 1 with no edges, tx_ready=1; transfer resumes correctly.
- Assert reset mid-bit in byte 2 -> spi_ss=1, spi_clk=1, busy=0 in the same cycle with no clock edge required; the next transaction is clean.
- CLK_DIV=1, SS_SETUP=1, SS_HOLD=1, one byte 8'hFF with tx_last -> 16 clk cycles of SPI clock, then ss high; busy clears after hold.
- (ABORT_EN) abort at bit 3 of byte 1 -> ss high next cycle, no rx_valid, busy drops after SS_HOLD.
